// File: rtl/alu_issue_unit.sv
// alu_issue_unit: queues ALU commands, issues them one at a time, returns result plus six flags in order.
// Latency: command accepted at edge N -> res_valid after edge N+1+ALU_LAT; one result per ALU_LAT+1 cycles.
// Backpressure: cmd_ready = !full (no same-cycle pop look-ahead); res_* held while res_valid & !res_ready.
// Optional macro ALU_ISSUE_FWD_EN: entries with cmd_fwd=1 take operand A from the last captured result.

// alu_issue_fifo: generic first-word-fall-through command buffer.
// Latency: written entry visible on pop_dat one edge after the push.
// Backpressure: push ignored while full, pop ignored while empty; push+pop together keep the count.
module alu_issue_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_vld,
    input  logic [DW-1:0] push_dat,
    input  logic          pop_vld,
    output logic [DW-1:0] pop_dat,
    output logic          full,
    output logic          empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push_vld && !full;
    assign do_pop  = pop_vld && !empty;
    assign pop_dat = mem[rd_ptr];

    // Storage array; contents are only meaningful below the count, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// alu_issue_unit: command FIFO in front of the ALU, single operation in flight, in-order results.
// Latency: accept at edge N, pop at N+1, result captured and res_valid high after edge N+1+ALU_LAT.
// Backpressure: holds one result plus DEPTH queued commands while res_ready is low.
module alu_issue_unit #(
    parameter int W       = 8,
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1,
    parameter int TAG_W   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [W-1:0]     cmd_a,
    input  logic [W-1:0]     cmd_b,
    input  logic             cmd_fwd,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [W-1:0]     alu_A,
    output logic [W-1:0]     alu_B,
    output logic [3:0]       alu_s,
    output logic             alu_R_W,
    input  logic [W-1:0]     alu_F,
    input  logic             alu_zeroflag,
    input  logic             alu_CarryOut,
    input  logic             alu_overflow,
    input  logic             alu_EQ,
    input  logic             alu_GT,
    input  logic             alu_LT,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [W-1:0]     res_f,
    output logic [5:0]       res_flags,
    output logic [TAG_W-1:0] res_tag
);
    typedef struct packed {
`ifdef ALU_ISSUE_FWD_EN
        logic             fwd;
`endif
        logic [3:0]       op;
        logic [W-1:0]     a;
        logic [W-1:0]     b;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam int              CNT_W    = $clog2(ALU_LAT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ALU_LAT - 1);

    state_t           state_q;
    state_t           state_d;
    logic             pop;
    logic             capture;
    logic             full;
    logic             empty;
    cmd_t             fifo_in;
    cmd_t             head;
    logic [W-1:0]     issue_a;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       iss_op;
    logic [W-1:0]     iss_a;
    logic [W-1:0]     iss_b;
    logic [TAG_W-1:0] iss_tag;

    assign cmd_ready = !full;

    // Pack the incoming command; the forward bit is only stored when forwarding exists.
    always_comb begin
        fifo_in     = '0;
`ifdef ALU_ISSUE_FWD_EN
        fifo_in.fwd = cmd_fwd;
`endif
        fifo_in.op  = cmd_op;
        fifo_in.a   = cmd_a;
        fifo_in.b   = cmd_b;
        fifo_in.tag = cmd_tag;
    end

`ifdef ALU_ISSUE_FWD_EN
    // Pop happens only after the previous capture, so res_f is always the preceding result.
    assign issue_a = head.fwd ? res_f : head.a;
`else
    logic unused_fwd;
    assign unused_fwd = cmd_fwd;
    assign issue_a    = head.a;
`endif

    alu_issue_fifo #(
        .DW    ($bits(cmd_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (cmd_valid),
        .push_dat (fifo_in),
        .pop_vld  (pop),
        .pop_dat  (head),
        .full     (full),
        .empty    (empty)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, pop/capture strobes, and ALU port / res_valid drive.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        capture   = 1'b0;
        res_valid = 1'b0;
        alu_A     = '0;
        alu_B     = '0;
        alu_s     = '0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                alu_A = iss_a;
                alu_B = iss_b;
                alu_s = iss_op;
                if (cnt_q == LAST_CNT) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                res_valid = 1'b1;
                alu_A     = iss_a;
                alu_B     = iss_b;
                alu_s     = iss_op;
                if (res_ready) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Issue register loaded on pop; latency counter restarts at pop and counts EXEC edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_op  <= '0;
            iss_a   <= '0;
            iss_b   <= '0;
            iss_tag <= '0;
            cnt_q   <= '0;
        end else if (pop) begin
            iss_op  <= head.op;
            iss_a   <= issue_a;
            iss_b   <= head.b;
            iss_tag <= head.tag;
            cnt_q   <= '0;
        end else if (state_q == EXEC) begin
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

    // Result register; res_f doubles as the last-result source for forwarding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_f     <= '0;
            res_flags <= '0;
            res_tag   <= '0;
        end else if (capture) begin
            res_f     <= alu_F;
            res_flags <= {alu_zeroflag, alu_CarryOut, alu_overflow, alu_EQ, alu_GT, alu_LT};
            res_tag   <= iss_tag;
        end
    end

    // ALU enable rises on the first edge out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_R_W <= 1'b0;
        end else begin
            alu_R_W <= 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_issue_unit.sv
`timescale 1ns/1ps
module tb_alu_issue_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid, cmd_ready, cmd_fwd;
    logic [3:0] cmd_op;
    logic [7:0] cmd_a, cmd_b;
    logic [2:0] cmd_tag;
    logic [7:0] alu_A, alu_B, alu_F;
    logic [3:0] alu_s;
    logic       alu_R_W;
    logic       alu_zeroflag, alu_CarryOut, alu_overflow, alu_EQ, alu_GT, alu_LT;
    logic       res_valid, res_ready;
    logic [7:0] res_f;
    logic [5:0] res_flags;
    logic [2:0] res_tag;

    alu_issue_unit #(.W(8), .DEPTH(4), .ALU_LAT(1), .TAG_W(3)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_fwd(cmd_fwd), .cmd_tag(cmd_tag),
        .alu_A(alu_A), .alu_B(alu_B), .alu_s(alu_s), .alu_R_W(alu_R_W),
        .alu_F(alu_F), .alu_zeroflag(alu_zeroflag), .alu_CarryOut(alu_CarryOut),
        .alu_overflow(alu_overflow), .alu_EQ(alu_EQ), .alu_GT(alu_GT), .alu_LT(alu_LT),
        .res_valid(res_valid), .res_ready(res_ready), .res_f(res_f),
        .res_flags(res_flags), .res_tag(res_tag)
    );

    always #5 clk = ~clk;

    // Combinational ALU stand-in (ALU_LAT=1): 0 add, 1 sub (carry = borrow), 2 and, 3 or, 4 xor.
    logic [8:0] alu_wide;
    always_comb begin
        alu_wide     = '0;
        alu_overflow = 1'b0;
        case (alu_s)
            4'd0: begin
                alu_wide     = {1'b0, alu_A} + {1'b0, alu_B};
                alu_overflow = (alu_A[7] == alu_B[7]) && (alu_wide[7] != alu_A[7]);
            end
            4'd1: begin
                alu_wide     = {1'b0, alu_A} - {1'b0, alu_B};
                alu_overflow = (alu_A[7] != alu_B[7]) && (alu_wide[7] != alu_A[7]);
            end
            4'd2:    alu_wide = {1'b0, alu_A & alu_B};
            4'd3:    alu_wide = {1'b0, alu_A | alu_B};
            4'd4:    alu_wide = {1'b0, alu_A ^ alu_B};
            default: alu_wide = '0;
        endcase
        alu_F        = alu_wide[7:0];
        alu_CarryOut = (alu_s == 4'd0 || alu_s == 4'd1) ? alu_wide[8] : 1'b0;
        alu_zeroflag = (alu_wide[7:0] == 8'h00);
        alu_EQ       = (alu_A == alu_B);
        alu_GT       = (alu_A > alu_B);
        alu_LT       = (alu_A < alu_B);
    end

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] tag;
        logic [7:0] ef;
        logic [5:0] efl;
    } vec_t;

    typedef struct {
        logic [7:0] f;
        logic [5:0] fl;
        logic [2:0] tag;
    } exp_t;

    vec_t  vecs [8];
    exp_t  exp_q [$];
    int    hs_q [$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    logic        stall_q = 1'b0;
    logic [16:0] snap;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard side: compare each handshaken result against the head of the expected queue.
    always @(negedge clk) begin
        if (!rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check("res_stable_under_stall", {res_f, res_flags, res_tag}, snap);
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_result: got tag %0d f 0x%0h, expected none", res_tag, res_f);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check($sformatf("result_tag%0d", e.tag), {res_f, res_flags, res_tag}, {e.f, e.fl, e.tag});
                    hs_q.push_back(cyc);
                end
            end
            stall_q = res_valid && !res_ready;
            snap    = {res_f, res_flags, res_tag};
        end
    end

    // Offer one command until accepted (bounded); returns 1 ns after the accepting edge.
    task automatic push_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic [2:0] tag, input logic fwd,
                            input logic [7:0] ef, input logic [5:0] efl);
        int   n = 0;
        exp_t e;
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_fwd = fwd;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL push_timeout: cmd_ready stayed 0, expected 1 for tag %0d", tag);
        end else begin
            e.f = ef; e.fl = efl; e.tag = tag;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || res_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_done", {exp_q.size() == 0, !res_valid}, 2'b11);
    endtask

    logic        acc;
    logic        seen;
    logic [7:0]  fwd_exp;

    initial begin
        //            op     a      b      tag   f      {z,c,o,eq,gt,lt}
        vecs[0] = '{4'd0, 8'h08, 8'h02, 3'd1, 8'h0A, 6'b000010};
        vecs[1] = '{4'd0, 8'hFF, 8'hFF, 3'd2, 8'hFE, 6'b010100};
        vecs[2] = '{4'd1, 8'hF0, 8'hF0, 3'd3, 8'h00, 6'b100100};
        vecs[3] = '{4'd0, 8'h7F, 8'h01, 3'd4, 8'h80, 6'b001010};
        vecs[4] = '{4'd1, 8'h10, 8'h20, 3'd5, 8'hF0, 6'b010001};
        vecs[5] = '{4'd2, 8'h0F, 8'h3C, 3'd6, 8'h0C, 6'b000001};
        vecs[6] = '{4'd4, 8'hAA, 8'hAA, 3'd7, 8'h00, 6'b100100};
        vecs[7] = '{4'd3, 8'h80, 8'h01, 3'd0, 8'h81, 6'b000010};

        cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0; cmd_fwd = 1'b0;
        res_ready = 1'b0;

        // Reset state and release.
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {res_valid, res_f, res_flags, res_tag, alu_A, alu_B, alu_s, alu_R_W}, 64'd0);
        rst = 1'b1;
        #1;
        check("release_cmd_ready", cmd_ready, 1);
        check("release_alu_rw_before_edge", alu_R_W, 0);
        @(posedge clk);
        #1;
        check("release_alu_rw_after_edge", alu_R_W, 1);

        // Single add: latency from acceptance edge N.
        push_cmd(vecs[0].op, vecs[0].a, vecs[0].b, vecs[0].tag, 1'b0, vecs[0].ef, vecs[0].efl);
        check("lat_n0_valid", res_valid, 0);
        @(posedge clk);
        #1;
        check("lat_n1_valid", res_valid, 0);
        check("lat_n1_issue", {alu_A, alu_B, alu_s}, {8'h08, 8'h02, 4'd0});
        @(posedge clk);
        #1;
        check("lat_n2_valid", res_valid, 1);
        check("lat_n2_f", res_f, 8'h0A);
        res_ready = 1'b1;
        wait_drain();

        // Table run, back-to-back with res_ready high: order, values and spacing.
        hs_q.delete();
        for (int i = 0; i < 8; i++) begin
            push_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, 1'b0, vecs[i].ef, vecs[i].efl);
        end
        wait_drain();
        check("table_result_count", hs_q.size(), 8);
        for (int i = 1; i < hs_q.size(); i++) begin
            check($sformatf("table_spacing_%0d", i), hs_q[i] - hs_q[i-1], 2);
        end
        check("idle_alu_ports_zero", {alu_A, alu_B, alu_s}, 0);

        // Backpressure: one result plus four queued, sixth offer refused.
        res_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            logic [7:0] a;
            a = 8'h10 + 8'(i);
            cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = a; cmd_b = 8'h01; cmd_tag = 3'(i); cmd_fwd = 1'b0;
            @(negedge clk);
            acc = cmd_ready;
            check($sformatf("bp_ready_tag%0d", i), acc, (i < 5) ? 1 : 0);
            if (acc) begin
                exp_t e;
                e.f = a + 8'h01; e.fl = 6'b000010; e.tag = 3'(i);
                exp_q.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        res_ready = 1'b1;
        push_cmd(4'd0, 8'h15, 8'h01, 3'd5, 1'b0, 8'h16, 6'b000010);
        wait_drain();

        // Reset while EXEC with three commands still queued.
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_cmd(4'd0, 8'h20 + 8'(i), 8'h01, 3'(i), 1'b0, 8'h21 + 8'(i), 6'b000010);
        end
        res_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check("rst_pre_exec_issue", alu_A, 8'h21);
        rst = 1'b0;
        #1;
        check("rst_async_outputs", {res_valid, res_f, res_flags, res_tag, alu_A, alu_B, alu_s, alu_R_W}, 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("rst_held_outputs", {res_valid, res_f, res_flags, res_tag, alu_A, alu_B, alu_s, alu_R_W}, 64'd0);
        rst = 1'b1;
        #1;
        check("rst_release_ready", cmd_ready, 1);
        check("rst_release_rw_low", alu_R_W, 0);
        @(posedge clk);
        #1;
        check("rst_release_rw_high", alu_R_W, 1);
        res_ready = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        check("rst_no_stale_result", seen, 0);
        @(posedge clk);
        #1;

        // Forwarding: second command asks for the previous result as A.
`ifdef ALU_ISSUE_FWD_EN
        fwd_exp = 8'h08;
`else
        fwd_exp = 8'h53;
`endif
        push_cmd(4'd0, 8'h08, 8'h02, 3'd1, 1'b0, 8'h0A, 6'b000010);
        push_cmd(4'd1, 8'h55, 8'h02, 3'd2, 1'b1, fwd_exp, 6'b000010);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
